// File: rtl/serdes_k_pkg.sv
// Shared constants for the SerDes TX lane: 8b/10b K-character codes, the
// fixed IDLE/EOF lane words, per-byte K-flag patterns and the frame
// scheduler state encoding.
package serdes_k_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame

  // Lane words, low byte transmitted first.
  localparam logic [15:0] IdleWord = {8'h50, K28_5};
  localparam logic [15:0] EofWord  = {8'h00, K29_7};

  // Per-byte K flags, bit0 covers the low byte.
  localparam logic [1:0] KLow  = 2'b01;
  localparam logic [1:0] KNone = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StSof,
    StData,
    StEof,
    StDrain
  } tx_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
// Ports:
//   clk_i        - clock
//   rst_i        - asynchronous active-high reset
//   req_i[1:0]   - requests, bit0 = config, bit1 = user
//   update_i     - strobe: record grant_idx_i as the last granted source
//   grant_idx_i  - index of the source that owned the finished frame
//   gnt_o[1:0]   - one-hot combinational grant (00 when nothing requests)
// The last-granted index resets to user so that config wins the first tie.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       grant_idx_i,
  output logic [1:0] gnt_o
);

  logic last_q;  // 1 = user granted last

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= grant_idx_i;
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/serdes_tx_arbiter.sv
// Two-source frame scheduler for the 16-bit 8b/10b SerDes TX lane.
// Shares the lane between the config and user streams, wraps each frame in
// SOF/EOF K-words, keeps at least IDLE_GAP idle words between frames and
// fills every unused lane word with the comma idle word.
// Ports:
//   I_serdes_tx_clk              - lane clock (only clock)
//   I_rst                        - asynchronous active-high reset
//   I_cfg_valid/last/data        - config stream in, O_cfg_ready handshake
//   I_usr_valid/last/data        - user stream in, O_usr_ready handshake
//   O_serdes_data, O_data_is_k   - registered lane word and per-byte K flags
//   O_grant                      - registered one-hot frame owner {usr,cfg}
//   O_trunc                      - one-cycle pulse alongside a truncated EOF
module serdes_tx_arbiter
  import serdes_k_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 2,
  parameter int unsigned MAX_LEN  = 256,
  parameter logic [7:0]  CFG_TYPE = 8'h01,
  parameter logic [7:0]  USR_TYPE = 8'h02
) (
  input  logic        I_serdes_tx_clk,
  input  logic        I_rst,
  input  logic        I_cfg_valid,
  input  logic        I_cfg_last,
  input  logic [15:0] I_cfg_data,
  output logic        O_cfg_ready,
  input  logic        I_usr_valid,
  input  logic        I_usr_last,
  input  logic [15:0] I_usr_data,
  output logic        O_usr_ready,
  output logic [15:0] O_serdes_data,
  output logic [1:0]  O_data_is_k,
  output logic [1:0]  O_grant,
  output logic        O_trunc
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);
  localparam int unsigned GapW = $clog2(IDLE_GAP + 1);

  tx_state_e   state_q, state_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d, gap_inc;
  logic [LenW-1:0] len_cnt_q, len_cnt_d;
  logic        trunc_flag_q, trunc_flag_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  is_k_q, is_k_d;
  logic        trunc_q, trunc_d;

  logic [1:0]  req, arb_gnt;
  logic        arb_update;
  logic        in_xfer, accept;
  logic        sel_valid, sel_last;
  logic [15:0] sel_data;

  assign req = {I_usr_valid, I_cfg_valid};

  rr_arb2 u_arb (
    .clk_i       (I_serdes_tx_clk),
    .rst_i       (I_rst),
    .req_i       (req),
    .update_i    (arb_update),
    .grant_idx_i (grant_q[1]),
    .gnt_o       (arb_gnt)
  );

  // Readies decode only registered state, never the incoming valids.
  assign in_xfer     = (state_q == StData) || (state_q == StDrain);
  assign O_cfg_ready = in_xfer & grant_q[0];
  assign O_usr_ready = in_xfer & grant_q[1];

  assign sel_valid = grant_q[1] ? I_usr_valid : I_cfg_valid;
  assign sel_last  = grant_q[1] ? I_usr_last  : I_cfg_last;
  assign sel_data  = grant_q[1] ? I_usr_data  : I_cfg_data;
  assign accept    = in_xfer & (|grant_q) & sel_valid;

  // Idle count including the idle word emitted this cycle, so a frame may
  // start as soon as exactly IDLE_GAP idle words separate EOF from SOF.
  assign gap_inc = (gap_cnt_q == GapW'(IDLE_GAP)) ? gap_cnt_q : gap_cnt_q + GapW'(1);

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    len_cnt_d    = len_cnt_q;
    trunc_flag_d = trunc_flag_q;
    grant_d      = grant_q;
    data_d       = IdleWord;
    is_k_d       = KLow;
    trunc_d      = 1'b0;
    arb_update   = 1'b0;

    unique case (state_q)
      StIdle: begin
        gap_cnt_d = gap_inc;
        if ((gap_inc == GapW'(IDLE_GAP)) && (|req)) begin
          grant_d = arb_gnt;
          state_d = StSof;
        end
      end
      StSof: begin
        data_d       = {(grant_q[1] ? USR_TYPE : CFG_TYPE), K27_7};
        len_cnt_d    = '0;
        trunc_flag_d = 1'b0;
        state_d      = StData;
      end
      StData: begin
        // A stalled cycle falls through to the idle-word default.
        if (accept) begin
          data_d    = sel_data;
          is_k_d    = KNone;
          len_cnt_d = len_cnt_q + LenW'(1);
          if (sel_last) begin
            state_d = StEof;
          end else if (len_cnt_q == LenW'(MAX_LEN - 1)) begin
            state_d      = StEof;
            trunc_flag_d = 1'b1;
          end
        end
      end
      StEof: begin
        data_d     = EofWord;
        arb_update = 1'b1;
        gap_cnt_d  = '0;
        if (trunc_flag_q) begin
          trunc_d = 1'b1;
          state_d = StDrain;
        end else begin
          grant_d = 2'b00;
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Swallow the tail of a truncated frame; the lane already idles.
        gap_cnt_d = gap_inc;
        if (accept && sel_last) begin
          grant_d = 2'b00;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge I_serdes_tx_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q      <= StIdle;
      gap_cnt_q    <= '0;
      len_cnt_q    <= '0;
      trunc_flag_q <= 1'b0;
      grant_q      <= 2'b00;
      data_q       <= IdleWord;
      is_k_q       <= KLow;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      len_cnt_q    <= len_cnt_d;
      trunc_flag_q <= trunc_flag_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      is_k_q       <= is_k_d;
      trunc_q      <= trunc_d;
    end
  end

  assign O_serdes_data = data_q;
  assign O_data_is_k   = is_k_q;
  assign O_grant       = grant_q;
  assign O_trunc       = trunc_q;

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Directed bench for serdes_tx_arbiter with IDLE_GAP=2, MAX_LEN=4.
// Lane words are logged as {is_k, data}; source queues hold
// {bubble, last, data} entries, a bubble entry drops valid for one cycle.
module tb_serdes_tx_arbiter;

  localparam logic [17:0] W_IDLE    = 18'h150BC;
  localparam logic [17:0] W_EOF     = 18'h100FD;
  localparam logic [17:0] W_SOF_CFG = 18'h101FB;
  localparam logic [17:0] W_SOF_USR = 18'h102FB;
  localparam logic [17:0] BUBBLE    = 18'h20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0, cfg_last = 1'b0;
  logic [15:0] cfg_data = 16'h0;
  logic        cfg_ready;
  logic        usr_valid = 1'b0, usr_last = 1'b0;
  logic [15:0] usr_data = 16'h0;
  logic        usr_ready;
  logic [15:0] serdes_data;
  logic [1:0]  data_is_k;
  logic [1:0]  grant;
  logic        trunc;

  serdes_tx_arbiter #(
    .IDLE_GAP (2),
    .MAX_LEN  (4),
    .CFG_TYPE (8'h01),
    .USR_TYPE (8'h02)
  ) dut (
    .I_serdes_tx_clk (clk),
    .I_rst           (rst),
    .I_cfg_valid     (cfg_valid),
    .I_cfg_last      (cfg_last),
    .I_cfg_data      (cfg_data),
    .O_cfg_ready     (cfg_ready),
    .I_usr_valid     (usr_valid),
    .I_usr_last      (usr_last),
    .I_usr_data      (usr_data),
    .O_usr_ready     (usr_ready),
    .O_serdes_data   (serdes_data),
    .O_data_is_k     (data_is_k),
    .O_grant         (grant),
    .O_trunc         (trunc)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [17:0] cfg_src[$];
  logic [17:0] usr_src[$];
  int          cfg_pres, usr_pres;  // 0 nothing, 1 word, 2 bubble
  logic        cfg_rdy_prev, usr_rdy_prev;

  logic [17:0] lane_log[$];
  logic [1:0]  grant_log[$];
  logic        trunc_log[$];
  logic        cfg_rdy_log[$];
  logic        usr_rdy_log[$];

  task automatic present();
    cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = 16'h0; cfg_pres = 0;
    if (cfg_src.size() > 0) begin
      if (cfg_src[0][17]) cfg_pres = 2;
      else begin
        cfg_pres = 1; cfg_valid = 1'b1;
        cfg_last = cfg_src[0][16]; cfg_data = cfg_src[0][15:0];
      end
    end
    usr_valid = 1'b0; usr_last = 1'b0; usr_data = 16'h0; usr_pres = 0;
    if (usr_src.size() > 0) begin
      if (usr_src[0][17]) usr_pres = 2;
      else begin
        usr_pres = 1; usr_valid = 1'b1;
        usr_last = usr_src[0][16]; usr_data = usr_src[0][15:0];
      end
    end
  endtask

  task automatic consume();
    if ((cfg_pres == 1 && cfg_rdy_prev) || cfg_pres == 2) cfg_src.delete(0);
    if ((usr_pres == 1 && usr_rdy_prev) || usr_pres == 2) usr_src.delete(0);
  endtask

  // Each iteration: log what the last posedge produced, retire what it
  // accepted, present the next words, then note ready for the coming edge.
  task automatic run(input int cycles);
    lane_log.delete(); grant_log.delete(); trunc_log.delete();
    cfg_rdy_log.delete(); usr_rdy_log.delete();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      lane_log.push_back({data_is_k, serdes_data});
      grant_log.push_back(grant);
      trunc_log.push_back(trunc);
      consume();
      present();
      cfg_rdy_prev = cfg_ready;
      usr_rdy_prev = usr_ready;
      cfg_rdy_log.push_back(cfg_ready);
      usr_rdy_log.push_back(usr_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cfg_rdy_prev = 1'b0; usr_rdy_prev = 1'b0;
    repeat (2) @(negedge clk);
    present();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int first_sof;
    logic ok;
    #12;
    n_cmp++; if (serdes_data !== 16'h50BC) begin n_fail++;
      $display("FAIL rst_data: got %h want 50bc", serdes_data); end
    n_cmp++; if (data_is_k !== 2'b01) begin n_fail++;
      $display("FAIL rst_is_k: got %b want 01", data_is_k); end
    n_cmp++; if (grant !== 2'b00) begin n_fail++;
      $display("FAIL rst_grant: got %b want 00", grant); end
    n_cmp++; if (trunc !== 1'b0) begin n_fail++;
      $display("FAIL rst_trunc: got %b want 0", trunc); end
    n_cmp++; if ({cfg_ready, usr_ready} !== 2'b00) begin n_fail++;
      $display("FAIL rst_ready: got %b want 00", {cfg_ready, usr_ready}); end
    cfg_src.delete(); usr_src.delete();
    cfg_src.push_back(18'h15A5A);
    do_reset();
    run(6);
    first_sof = -1;
    for (int i = 5; i >= 0; i--) if (lane_log[i] === W_SOF_CFG) first_sof = i;
    ok = (first_sof >= 2);
    n_cmp++; if (ok !== 1'b1) begin n_fail++;
      $display("FAIL rst_gap: SOF at index %0d, want >= 2", first_sof); end
    n_cmp++; if (lane_log[0] !== W_IDLE) begin n_fail++;
      $display("FAIL rst_first_word: got %h want %h", lane_log[0], W_IDLE); end
  endtask

  task automatic test_cfg_frame();
    logic [17:0] exp_w [0:6];
    exp_w = '{W_SOF_CFG, 18'h0A1A1, 18'h0A2A2, 18'h0A3A3, W_EOF, W_IDLE, W_IDLE};
    cfg_src.delete(); usr_src.delete();
    cfg_src.push_back(18'h0A1A1); cfg_src.push_back(18'h0A2A2); cfg_src.push_back(18'h1A3A3);
    do_reset();
    run(10);
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (lane_log[i+2] !== exp_w[i]) begin n_fail++;
        $display("FAIL cfg_lane[%0d]: got %h want %h", i + 2, lane_log[i+2], exp_w[i]); end
    end
    n_cmp++; if (grant_log[3] !== 2'b01) begin n_fail++;
      $display("FAIL cfg_grant_open: got %b want 01", grant_log[3]); end
    n_cmp++; if (grant_log[7] !== 2'b00) begin n_fail++;
      $display("FAIL cfg_grant_closed: got %b want 00", grant_log[7]); end
    n_cmp++; if (usr_rdy_log[3] !== 1'b0) begin n_fail++;
      $display("FAIL cfg_usr_ready: got %b want 0", usr_rdy_log[3]); end
  endtask

  task automatic test_tie();
    int          idx [0:8];
    logic [17:0] exp_w [0:8];
    idx   = '{2, 3, 5, 6, 7, 8, 9, 14, 19};
    exp_w = '{W_SOF_CFG, 18'h01111, W_EOF, W_IDLE, W_IDLE, W_SOF_USR, 18'h02221,
              W_SOF_CFG, W_SOF_USR};
    cfg_src.delete(); usr_src.delete();
    cfg_src.push_back(18'h01111); cfg_src.push_back(18'h11112); cfg_src.push_back(18'h11113);
    usr_src.push_back(18'h02221); usr_src.push_back(18'h12222); usr_src.push_back(18'h12223);
    do_reset();
    run(24);
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (lane_log[idx[i]] !== exp_w[i]) begin n_fail++;
        $display("FAIL tie_lane[%0d]: got %h want %h", idx[i], lane_log[idx[i]], exp_w[i]); end
    end
  endtask

  task automatic test_stall();
    logic [17:0] exp_w [0:6];
    exp_w = '{W_SOF_USR, 18'h0B001, W_IDLE, W_IDLE, 18'h0B002, 18'h0B003, W_EOF};
    cfg_src.delete(); usr_src.delete();
    usr_src.push_back(18'h0B001); usr_src.push_back(BUBBLE); usr_src.push_back(BUBBLE);
    usr_src.push_back(18'h0B002); usr_src.push_back(18'h1B003);
    do_reset();
    run(11);
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (lane_log[i+2] !== exp_w[i]) begin n_fail++;
        $display("FAIL stall_lane[%0d]: got %h want %h", i + 2, lane_log[i+2], exp_w[i]); end
    end
    n_cmp++; if (grant_log[5] !== 2'b10) begin n_fail++;
      $display("FAIL stall_grant: got %b want 10", grant_log[5]); end
  endtask

  task automatic test_trunc();
    cfg_src.delete(); usr_src.delete();
    for (int i = 1; i <= 6; i++) usr_src.push_back({2'b00, 16'hC000 + 16'(i)});
    usr_src[5][16] = 1'b1;
    do_reset();
    run(12);
    n_cmp++; if (lane_log[5] !== 18'h0C003) begin n_fail++;
      $display("FAIL trunc_c3: got %h want 0c003", lane_log[5]); end
    n_cmp++; if (lane_log[6] !== 18'h0C004) begin n_fail++;
      $display("FAIL trunc_c4: got %h want 0c004", lane_log[6]); end
    n_cmp++; if (lane_log[7] !== W_EOF) begin n_fail++;
      $display("FAIL trunc_eof: got %h want %h", lane_log[7], W_EOF); end
    n_cmp++; if ({trunc_log[6], trunc_log[7], trunc_log[8]} !== 3'b010) begin n_fail++;
      $display("FAIL trunc_pulse: got %b want 010", {trunc_log[6], trunc_log[7], trunc_log[8]}); end
    n_cmp++; if (lane_log[8] !== W_IDLE) begin n_fail++;
      $display("FAIL trunc_drain0: got %h want %h", lane_log[8], W_IDLE); end
    n_cmp++; if (lane_log[9] !== W_IDLE) begin n_fail++;
      $display("FAIL trunc_drain1: got %h want %h", lane_log[9], W_IDLE); end
    n_cmp++; if ({usr_rdy_log[8], usr_rdy_log[9]} !== 2'b10) begin n_fail++;
      $display("FAIL trunc_ready: got %b want 10", {usr_rdy_log[8], usr_rdy_log[9]}); end
    n_cmp++; if (usr_src.size() !== 0) begin n_fail++;
      $display("FAIL trunc_drained: %0d words left, want 0", usr_src.size()); end
    n_cmp++; if (grant_log[10] !== 2'b00) begin n_fail++;
      $display("FAIL trunc_grant: got %b want 00", grant_log[10]); end
  endtask

  task automatic test_mid_reset();
    cfg_src.delete(); usr_src.delete();
    for (int i = 1; i <= 6; i++) usr_src.push_back({2'b00, 16'hC000 + 16'(i)});
    usr_src[5][16] = 1'b1;
    do_reset();
    run(5);
    n_cmp++; if (lane_log[4] !== 18'h0C002) begin n_fail++;
      $display("FAIL mid_c2: got %h want 0c002", lane_log[4]); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({data_is_k, serdes_data} !== W_IDLE) begin n_fail++;
      $display("FAIL mid_async_lane: got %h want %h", {data_is_k, serdes_data}, W_IDLE); end
    n_cmp++; if ({grant, usr_ready} !== 3'b000) begin n_fail++;
      $display("FAIL mid_async_ctl: got %b want 000", {grant, usr_ready}); end
    usr_src.delete();
    cfg_src.push_back(18'h1F001);
    do_reset();
    run(6);
    n_cmp++; if ({lane_log[0], lane_log[1]} !== {W_IDLE, W_IDLE}) begin n_fail++;
      $display("FAIL mid_no_eof: got %h %h want idle idle", lane_log[0], lane_log[1]); end
    n_cmp++; if (lane_log[2] !== W_SOF_CFG) begin n_fail++;
      $display("FAIL mid_sof: got %h want %h", lane_log[2], W_SOF_CFG); end
    n_cmp++; if (lane_log[3] !== 18'h0F001) begin n_fail++;
      $display("FAIL mid_data: got %h want 0f001", lane_log[3]); end
    n_cmp++; if (lane_log[4] !== W_EOF) begin n_fail++;
      $display("FAIL mid_eof: got %h want %h", lane_log[4], W_EOF); end
  endtask

  initial begin
    test_reset();
    test_cfg_frame();
    test_tie();
    test_stall();
    test_trunc();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
